// File: rtl/led_frame_buffer.sv
// Double-buffered HUB75 pixel store: the writer fills the back bank and the panel driver reads
// bit-planes from the front bank. Bank swaps commit only at the driver's frame boundary.
module led_frame_buffer #(
  parameter int COLS       = 64,
  parameter int ROW_PAIRS  = 16,
  parameter int COLOR_BITS = 4,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROW_PAIRS),
  localparam int PW = $clog2(COLOR_BITS),
  localparam int WW = 3 * COLOR_BITS
) (
  input  logic          CLK_100MHz,
  input  logic          RESET,
  input  logic          WR_EN,
  input  logic [CW-1:0] WR_X,
  input  logic [RW:0]   WR_Y,
  input  logic [WW-1:0] WR_RGB,
  input  logic          SWAP_REQ,
  output logic          SWAP_BUSY,
  output logic          SWAP_ACK,
  input  logic          FRAME_DONE,
  input  logic          RD_EN,
  input  logic [RW-1:0] RD_ROW,
  input  logic [CW-1:0] RD_COL,
  input  logic [PW-1:0] RD_PLANE,
  output logic          RD_VALID,
  output logic          R1,
  output logic          G1,
  output logic          B1,
  output logic          R2,
  output logic          G2,
  output logic          B2
);

  localparam int AW    = RW + CW;
  localparam int DEPTH = COLS * ROW_PAIRS;
  localparam logic [PW:0] PLANE_LIM = (PW + 1)'(COLOR_BITS);

  typedef enum logic [0:0] {IDLE = 1'b0, PENDING = 1'b1} swap_state_t;

  swap_state_t state_r, state_nxt_s;
  logic        commit_s;
  logic        front_r;
  logic        ack_r;

  // [bank][half][{row,col}]; half 0 is the upper panel half
  logic [WW-1:0] mem_r [2][2][DEPTH];
  logic [WW-1:0] word_u_r, word_l_r;
  logic          v1_r;
  logic [PW-1:0] plane_r;
  logic          rd_valid_r;
  logic [5:0]    bits_r;
  logic [5:0]    plane_bits_s;
  logic [AW-1:0] wr_addr_s, rd_addr_s;

  assign wr_addr_s = {WR_Y[RW-1:0], WR_X};
  assign rd_addr_s = {RD_ROW, RD_COL};

  function automatic logic [2:0] plane_rgb(input logic [WW-1:0] w, input logic [PW-1:0] p);
    logic [COLOR_BITS-1:0] r, g, b;
    r = w[WW-1 -: COLOR_BITS];
    g = w[2*COLOR_BITS-1 -: COLOR_BITS];
    b = w[COLOR_BITS-1:0];
    return {r[p], g[p], b[p]};
  endfunction

  // Swap FSM state register, front-bank select and acknowledge pulse
  always_ff @(posedge CLK_100MHz) begin
    if (RESET) begin
      state_r <= IDLE;
      front_r <= 1'b0;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      front_r <= front_r ^ commit_s;
      ack_r   <= commit_s;
    end
  end

  // Swap FSM next state; a request meeting a frame boundary while idle commits without pending
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (SWAP_REQ && !FRAME_DONE) state_nxt_s = PENDING;
        else                         state_nxt_s = IDLE;
      end
      PENDING: begin
        if (FRAME_DONE) state_nxt_s = IDLE;
        else            state_nxt_s = PENDING;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Swap FSM outputs: commit strobe toggles the front bank
  always_comb begin
    commit_s = 1'b0;
    case (state_r)
      IDLE:    commit_s = SWAP_REQ && FRAME_DONE;
      PENDING: commit_s = FRAME_DONE;
      default: commit_s = 1'b0;
    endcase
  end

  // Pixel storage: writes to the back bank, synchronous reads from the front bank
  always_ff @(posedge CLK_100MHz) begin
    if (WR_EN) begin
      mem_r[~front_r][WR_Y[RW]][wr_addr_s] <= WR_RGB;
    end
    word_u_r <= mem_r[front_r][1'b0][rd_addr_s];
    word_l_r <= mem_r[front_r][1'b1][rd_addr_s];
  end

  // Bit-plane select; planes beyond the colour depth read as black
  always_comb begin
    plane_bits_s = 6'b000000;
    if ({1'b0, plane_r} < PLANE_LIM) begin
      plane_bits_s = {plane_rgb(word_u_r, plane_r), plane_rgb(word_l_r, plane_r)};
    end else begin
      plane_bits_s = 6'b000000;
    end
  end

  // Read pipeline control and registered driver outputs
  always_ff @(posedge CLK_100MHz) begin
    if (RESET) begin
      v1_r       <= 1'b0;
      plane_r    <= '0;
      rd_valid_r <= 1'b0;
      bits_r     <= 6'b000000;
    end else begin
      v1_r       <= RD_EN;
      plane_r    <= RD_PLANE;
      rd_valid_r <= v1_r;
      bits_r     <= v1_r ? plane_bits_s : 6'b000000;
    end
  end

  assign SWAP_BUSY = (state_r == PENDING);
  assign SWAP_ACK  = ack_r;
  assign RD_VALID  = rd_valid_r;
  assign {R1, G1, B1, R2, G2, B2} = bits_r;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Scoreboard bench for led_frame_buffer: reads push expected plane bits with their due cycle,
// monitors pop and compare whenever RD_VALID is seen. A second instance uses 3-bit colour.
module tb_led_frame_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic wr_en = 1'b0, swap_req = 1'b0, frame_done = 1'b0, rd_en = 1'b0;
  logic [5:0] wr_x = '0, rd_col = '0;
  logic [4:0] wr_y = '0;
  logic [11:0] wr_rgb = '0;
  logic [3:0] rd_row = '0;
  logic [1:0] rd_plane = '0;
  logic swap_busy, swap_ack, rd_valid, r1, g1, b1, r2, g2, b2;

  logic b_wr_en = 1'b0, b_swap_req = 1'b0, b_frame_done = 1'b0, b_rd_en = 1'b0;
  logic [5:0] b_wr_x = '0, b_rd_col = '0;
  logic [4:0] b_wr_y = '0;
  logic [8:0] b_wr_rgb = '0;
  logic [3:0] b_rd_row = '0;
  logic [1:0] b_rd_plane = '0;
  logic b_swap_busy, b_swap_ack, b_rd_valid, b_r1, b_g1, b_b1, b_r2, b_g2, b_b2;

  led_frame_buffer dut (
    .CLK_100MHz(clk), .RESET(reset), .WR_EN(wr_en), .WR_X(wr_x), .WR_Y(wr_y), .WR_RGB(wr_rgb),
    .SWAP_REQ(swap_req), .SWAP_BUSY(swap_busy), .SWAP_ACK(swap_ack), .FRAME_DONE(frame_done),
    .RD_EN(rd_en), .RD_ROW(rd_row), .RD_COL(rd_col), .RD_PLANE(rd_plane), .RD_VALID(rd_valid),
    .R1(r1), .G1(g1), .B1(b1), .R2(r2), .G2(g2), .B2(b2)
  );

  led_frame_buffer #(.COLS(64), .ROW_PAIRS(16), .COLOR_BITS(3)) dut3 (
    .CLK_100MHz(clk), .RESET(reset), .WR_EN(b_wr_en), .WR_X(b_wr_x), .WR_Y(b_wr_y),
    .WR_RGB(b_wr_rgb), .SWAP_REQ(b_swap_req), .SWAP_BUSY(b_swap_busy), .SWAP_ACK(b_swap_ack),
    .FRAME_DONE(b_frame_done), .RD_EN(b_rd_en), .RD_ROW(b_rd_row), .RD_COL(b_rd_col),
    .RD_PLANE(b_rd_plane), .RD_VALID(b_rd_valid),
    .R1(b_r1), .G1(b_g1), .B1(b_b1), .R2(b_r2), .G2(b_g2), .B2(b_b2)
  );

  typedef struct {
    int         cyc;
    logic [5:0] bits;
  } exp_t;

  exp_t q[$];
  exp_t q3[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] pb(input logic [11:0] rgb, input int p);
    return {rgb[8+p], rgb[4+p], rgb[p]};
  endfunction

  function automatic logic [11:0] ru(input int c);
    return 12'(c * 53 + 7);
  endfunction

  function automatic logic [11:0] rl(input int c);
    return 12'(c * 29 + 100);
  endfunction

  task automatic wr(input logic [5:0] x, input logic [4:0] y, input logic [11:0] rgb);
    wr_en = 1'b1; wr_x = x; wr_y = y; wr_rgb = rgb;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_rd(input logic [3:0] row, input logic [5:0] col, input logic [1:0] pl,
                       input logic [5:0] exp);
    exp_t e;
    rd_en = 1'b1; rd_row = row; rd_col = col; rd_plane = pl;
    e.cyc = cyc + 2; e.bits = exp;
    q.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic b_wr(input logic [5:0] x, input logic [4:0] y, input logic [8:0] rgb);
    b_wr_en = 1'b1; b_wr_x = x; b_wr_y = y; b_wr_rgb = rgb;
    tick();
    b_wr_en = 1'b0;
  endtask

  task automatic b_do_rd(input logic [1:0] pl, input logic [5:0] exp);
    exp_t e;
    b_rd_en = 1'b1; b_rd_row = 4'd0; b_rd_col = 6'd0; b_rd_plane = pl;
    e.cyc = cyc + 2; e.bits = exp;
    q3.push_back(e);
    tick();
    b_rd_en = 1'b0;
  endtask

  // Monitor for the 4-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rd_valid: RD_VALID=1 with no read outstanding (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("rd_latency", cyc, e.cyc);
        chk("rd_bits", {r1, g1, b1, r2, g2, b2}, e.bits);
      end
    end
  end

  // Monitor for the 3-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (b_rd_valid === 1'b1) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rd_valid3: RD_VALID=1 with no read outstanding (cycle %0d)", cyc);
      end else begin
        e = q3.pop_front();
        chk("rd_latency3", cyc, e.cyc);
        chk("rd_bits3", {b_r1, b_g1, b_b1, b_r2, b_g2, b_b2}, e.bits);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic busy_lost, ack_seen, extra_ack;

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_swap_busy", swap_busy, 0);
    chk("reset_swap_ack", swap_ack, 0);
    chk("reset_bits", {r1, g1, b1, r2, g2, b2}, 0);

    // Fill back bank (bank 1)
    wr(6'd5, 5'd3, 12'hA53);
    wr(6'd5, 5'd19, 12'h1F0);
    for (int c = 0; c < 64; c++) begin
      wr(6'(c), 5'd0, ru(c));
      wr(6'(c), 5'd16, rl(c));
    end

    // Request and frame boundary in the same cycle: immediate commit
    swap_req = 1'b1; frame_done = 1'b1;
    tick();
    swap_req = 1'b0; frame_done = 1'b0;
    chk("same_cycle_ack", swap_ack, 1);
    chk("same_cycle_busy", swap_busy, 0);
    tick();
    chk("ack_one_pulse", swap_ack, 0);
    chk("same_cycle_busy_after", swap_busy, 0);

    // Bit-plane reads of row 3 col 5
    do_rd(4'd3, 6'd5, 2'd0, 6'b011_110);
    do_rd(4'd3, 6'd5, 2'd1, 6'b101_010);
    do_rd(4'd3, 6'd5, 2'd2, 6'b010_010);
    do_rd(4'd3, 6'd5, 2'd3, 6'b100_010);

    // 64 back-to-back reads, plane 2
    for (int c = 0; c < 64; c++) begin
      do_rd(4'd0, 6'(c), 2'd2, {pb(ru(c), 2), pb(rl(c), 2)});
    end

    // New contents into bank 0, lone frame boundary has no effect
    wr(6'd5, 5'd3, 12'h5AC);
    wr(6'd5, 5'd19, 12'h3C7);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("fd_idle_no_ack", swap_ack, 0);
    chk("fd_idle_no_busy", swap_busy, 0);
    do_rd(4'd3, 6'd5, 2'd0, 6'b011_110);

    // Pending swap held for 100 cycles, second request ignored
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("busy_after_req", swap_busy, 1);
    busy_lost = 1'b0; ack_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 10) swap_req = 1'b1;
      if (i == 50) do_rd(4'd3, 6'd5, 2'd0, 6'b011_110);
      else tick();
      swap_req = 1'b0;
      busy_lost = busy_lost | ~swap_busy;
      ack_seen  = ack_seen | swap_ack;
    end
    chk("busy_held", busy_lost, 0);
    chk("no_early_ack", ack_seen, 0);

    // Commit: read in the commit cycle sees the old bank, the next one the new bank
    frame_done = 1'b1;
    do_rd(4'd3, 6'd5, 2'd0, 6'b011_110);
    frame_done = 1'b0;
    chk("ack_after_fd", swap_ack, 1);
    chk("busy_clear_on_commit", swap_busy, 0);
    do_rd(4'd3, 6'd5, 2'd0, 6'b100_101);
    chk("ack_drops", swap_ack, 0);
    extra_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      extra_ack = extra_ack | swap_ack;
    end
    chk("single_ack", extra_ack, 0);

    // Reset with swap pending and a read in flight
    swap_req = 1'b1; frame_done = 1'b1;
    tick();
    swap_req = 1'b0; frame_done = 1'b0;
    chk("ack_before_reset", swap_ack, 1);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("busy_before_reset", swap_busy, 1);
    rd_en = 1'b1; rd_row = 4'd3; rd_col = 6'd5; rd_plane = 2'd0;
    tick();
    rd_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_swap_busy", swap_busy, 0);
    chk("rst_swap_ack", swap_ack, 0);
    chk("rst_bits", {r1, g1, b1, r2, g2, b2}, 0);
    tick();
    chk("rst_busy_stays_clear", swap_busy, 0);
    do_rd(4'd3, 6'd5, 2'd1, 6'b010_101);

    // 3-bit colour instance: plane 3 is out of range
    b_wr(6'd0, 5'd0, 9'h1FF);
    b_wr(6'd0, 5'd16, 9'h0A5);
    b_swap_req = 1'b1; b_frame_done = 1'b1;
    tick();
    b_swap_req = 1'b0; b_frame_done = 1'b0;
    chk("ack3", b_swap_ack, 1);
    b_do_rd(2'd3, 6'b000_000);
    b_do_rd(2'd2, 6'b111_011);
    b_do_rd(2'd0, 6'b111_001);

    for (int i = 0; i < 20 && (q.size() != 0 || q3.size() != 0); i++) tick();
    tick();
    chk("queue_drained", q.size(), 0);
    chk("queue_drained3", q3.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
